ram_top: RTL and testbench



---
 rtl/ram_top_pkg.sv | 12 +
 rtl/ram_top_seg7_scan.sv | 28 ++
 rtl/ram_top.sv | 50 +++++
 tb/tb_ram_top.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ram_top_pkg.sv
// ram_top_pkg: write-data constants, memory depth and seven-segment decode table
package ram_top_pkg;
    localparam int MEM_WORDS = 64;
    localparam logic [3:0][31:0] WDATA = {32'hFFFF_FFFF, 32'h89AB_CDEF, 32'h1234_5678, 32'h0000_0000};
    // gfedcba, active-low, indexed by hex digit (entry 15 first)
    localparam logic [15:0][6:0] SEG7 = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
endpackage

// File: rtl/ram_top_seg7_scan.sv
// seg7_scan: free-running scan of a 16-bit value onto a 4-digit active-low display
module seg7_scan
    import ram_top_pkg::*;
#(
    parameter int SCAN_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [3:0]  AN,
    output logic [7:0]  seg
);
    logic [SCAN_BITS-1:0] cnt;
    logic [1:0] dsel;
    logic [3:0] nib;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= cnt + SCAN_BITS'(1);

    assign dsel = cnt[SCAN_BITS-1 -: 2];

    always_comb begin
        AN  = ~(4'b0001 << dsel);
        nib = value[{dsel, 2'b00} +: 4];
        seg = {1'b1, SEG7[nib]};
    end
endmodule

// File: rtl/ram_top.sv
// ram_top: 64x32 data RAM written from fixed constants on a debounced strobe, shown on seven-segment
module ram_top
    import ram_top_pkg::*;
#(
    parameter int SCAN_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Mem_Write,
    input  logic [7:2] DM_Addr,
    input  logic [1:0] MW_Data_s,
    input  logic       clk_dm,
    output logic [3:0] AN,
    output logic [7:0] seg
);
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rdata;
    logic s1, s2, e;
    logic [1:0] arm;
    logic wr_pulse;

    // arm keeps a strobe already high at reset release from looking like a fresh edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {s1, s2, e} <= 3'b000;
            arm <= 2'd0;
        end else begin
            {s1, s2, e} <= {clk_dm, s1, s2};
            if (arm != 2'd3) arm <= arm + 2'd1;
        end

    assign wr_pulse = s2 & ~e & (arm == 2'd3);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (wr_pulse && Mem_Write) begin
            mem[DM_Addr] <= WDATA[MW_Data_s];
        end

    assign rdata = mem[DM_Addr];

    seg7_scan #(.SCAN_BITS(SCAN_BITS)) u_scan (
        .clk  (clk),
        .rst  (rst),
        .value(rdata[15:0]),
        .AN   (AN),
        .seg  (seg)
    );
endmodule

// File: tb/tb_ram_top.sv
// tb_ram_top: randomized writes against an array model; display checked digit by digit
module tb_ram_top;
    logic       clk = 0, rst = 0, Mem_Write = 0, clk_dm = 0;
    logic [7:2] DM_Addr = 0;
    logic [1:0] MW_Data_s = 0;
    logic [3:0] AN;
    logic [7:0] seg;
    int tests = 0, errs = 0;
    int ncyc;
    logic [31:0] model [64];
    logic [31:0] wconst [4] = '{32'h0000_0000, 32'h1234_5678, 32'h89AB_CDEF, 32'hFFFF_FFFF};
    logic [6:0] hex [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    ram_top #(.SCAN_BITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .Mem_Write(Mem_Write),
        .DM_Addr  (DM_Addr),
        .MW_Data_s(MW_Data_s),
        .clk_dm   (clk_dm),
        .AN       (AN),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    // rising edges since reset release; each digit owns 4 of every 16
    always @(posedge clk or posedge rst)
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_word(input int a, input bit show);
        int d;
        logic [3:0] ea;
        DM_Addr = 6'(a);
        #1 check($sformatf("rdata[%0d]", a), dut.rdata, model[a]);
        if (show)
            repeat (16) begin
                @(negedge clk);
                d  = (ncyc / 4) % 4;
                ea = 4'b1111 ^ (4'b0001 << d);
                check("an", AN, ea);
                check($sformatf("seg[%0d].%0d", a, d), seg, {1'b1, hex[(model[a] >> (4 * d)) & 15]});
            end
    endtask

    task automatic do_write(input bit we, input int a, input int sel, input int hold);
        Mem_Write = we; DM_Addr = 6'(a); MW_Data_s = 2'(sel);
        clk_dm = 1;
        tick(hold);
        clk_dm = 0;
        tick(4);
        if (we) model[a] = wconst[sel];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int a;
        foreach (model[i]) model[i] = '0;
        rst = 1;
        tick(3);
        check("rst_an", AN, 4'b1110);
        check("rst_seg", seg, 8'hC0);
        rst = 0;
        #1 check("rel_an", AN, 4'b1110);
        check("rel_seg", seg, 8'hC0);
        tick(4);
        check_word(0, 1);
        // write latency: lands on the 3rd rising edge after the strobe goes high
        Mem_Write = 1; DM_Addr = 0; MW_Data_s = 1; clk_dm = 1;
        tick(2);
        check("lat2", dut.rdata, 32'h0);
        tick(1);
        check("lat3", dut.rdata, 32'h1234_5678);
        clk_dm = 0;
        tick(4);
        model[0] = wconst[1];
        check_word(0, 1);
        do_write(1, 63, 2, 3);
        do_write(1, 1, 3, 2);
        check_word(63, 1);
        check_word(1, 0);
        check_word(2, 0);
        do_write(0, 4, 1, 3);
        check_word(4, 0);
        // long hold: one write only, later select change ignored
        Mem_Write = 1; DM_Addr = 7; MW_Data_s = 1; clk_dm = 1;
        tick(10);
        MW_Data_s = 2;
        tick(90);
        clk_dm = 0;
        tick(4);
        model[7] = wconst[1];
        check_word(7, 0);
        repeat (24) do_write(1'($urandom_range(1)), $urandom_range(63), $urandom_range(3), $urandom_range(8, 2));
        repeat (8) check_word($urandom_range(63), 0);
        check_word($urandom_range(63), 1);
        rst = 1;
        tick(2);
        foreach (model[i]) model[i] = '0;
        for (int i = 0; i < 64; i++) check_word(i, 0);
        // strobe already high at release must not write
        clk_dm = 1; Mem_Write = 1; DM_Addr = 5; MW_Data_s = 1;
        tick(1);
        rst = 0;
        tick(10);
        check_word(5, 0);
        clk_dm = 0;
        tick(4);
        check_word(5, 0);
        do_write(1, 5, 2, 2);
        check_word(5, 1);
        // reset while a pulse is in the synchronizer discards it
        Mem_Write = 1; DM_Addr = 9; MW_Data_s = 3; clk_dm = 1;
        tick(2);
        rst = 1;
        clk_dm = 0;
        tick(2);
        foreach (model[i]) model[i] = '0;
        rst = 0;
        tick(6);
        check_word(9, 0);
        check_word(5, 0);
        a = $urandom_range(63);
        do_write(1, a, 3, 2);
        check_word(a, 1);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
